pbwc_multi: RTL and testbench

PBWC_MULTI -- requirements
Module: pbwc_multi

---
 rtl/pbwc_multi.sv | 177 +++++++++++++++++
 tb/tb_pbwc_multi.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pbwc_multi.sv
// rtl/pbwc_multi.sv - multi-channel push-button window controller with debounce and travel timing
module pbwc_multi #(
   parameter int CH            = 4,
   parameter int DEB_CYCLES    = 4,
   parameter int TRAVEL_CYCLES = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [CH-1:0] PRESS,
   input  logic          ALL_CLOSE,
   output logic [CH-1:0] OPEN_CW,
   output logic [CH-1:0] CLOSE_CW,
   output logic [CH-1:0] IS_OPEN,
   output logic          BUSY
);

   localparam int PW = $clog2(TRAVEL_CYCLES + 1);
   // The debounce counter clears instead of storing DEB_CYCLES, so it only needs to hold DEB_CYCLES-1.
   localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
   localparam logic [PW-1:0] TRAVEL    = PW'(TRAVEL_CYCLES);
   localparam logic [PW-1:0] TRAVEL_M1 = PW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPENING = 2'd1,
      OPEN    = 2'd2,
      CLOSING = 2'd3
   } state_t;

   logic [CH-1:0] sync1_q, sync2_q;
   logic [CH-1:0] deb_q, deb_d;
   logic [CH-1:0] evt_q, evt_d;
   logic [DW-1:0] deb_cnt_q [CH];
   logic [DW-1:0] deb_cnt_d [CH];

   state_t        state_q [CH];
   state_t        state_d [CH];
   logic [PW-1:0] pos_q [CH];
   logic [PW-1:0] pos_d [CH];

   logic [CH-1:0] open_cw_q, open_cw_d;
   logic [CH-1:0] close_cw_q, close_cw_d;
   logic [CH-1:0] is_open_q, is_open_d;
   logic          busy_q, busy_d;

   // Debounce: count cycles of disagreement, adopt the input once it has been stable long enough,
   // and emit a one-cycle event only when the adopted level rises.
   always_comb begin
      deb_d = deb_q;
      evt_d = '0;
      for (int i = 0; i < CH; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
               evt_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Synchroniser, debounce and press-event registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         evt_q   <= '0;
         for (int i = 0; i < CH; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= PRESS;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         evt_q   <= evt_d;
         for (int i = 0; i < CH; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
      end
   end

   // Per-channel window FSM: ALL_CLOSE beats a press, a press beats travel completion.
   // Any state change caused by ALL_CLOSE or a press holds POS so reversal time equals elapsed time.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         pos_d[i]   = pos_q[i];
         case (state_q[i])
            CLOSED: begin
               if (!ALL_CLOSE && evt_q[i]) begin
                  state_d[i] = OPENING;
               end
            end
            OPENING: begin
               if (ALL_CLOSE || evt_q[i]) begin
                  state_d[i] = CLOSING;
               end else if (pos_q[i] >= TRAVEL) begin
                  state_d[i] = OPEN;
                  pos_d[i]   = TRAVEL;
               end else begin
                  pos_d[i] = pos_q[i] + 1'b1;
                  if (pos_q[i] == TRAVEL_M1) begin
                     state_d[i] = OPEN;
                  end
               end
            end
            OPEN: begin
               if (ALL_CLOSE || evt_q[i]) begin
                  state_d[i] = CLOSING;
               end
            end
            CLOSING: begin
               if (!ALL_CLOSE && evt_q[i]) begin
                  state_d[i] = OPENING;
               end else if (pos_q[i] == '0) begin
                  state_d[i] = CLOSED;
               end else begin
                  pos_d[i] = pos_q[i] - 1'b1;
                  if (pos_q[i] == PW'(1)) begin
                     state_d[i] = CLOSED;
                  end
               end
            end
            default: begin
               state_d[i] = CLOSED;
               pos_d[i]   = '0;
            end
         endcase
      end
   end

   // Moore output decodes, computed from the next state so they register alongside it.
   always_comb begin
      open_cw_d  = '0;
      close_cw_d = '0;
      is_open_d  = '0;
      for (int i = 0; i < CH; i++) begin
         open_cw_d[i]  = (state_d[i] == OPENING);
         close_cw_d[i] = (state_d[i] == CLOSING);
         is_open_d[i]  = (state_d[i] == OPEN);
      end
      busy_d = |(open_cw_d | close_cw_d);
   end

   // FSM state, position and registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= CLOSED;
            pos_q[i]   <= '0;
         end
         open_cw_q  <= '0;
         close_cw_q <= '0;
         is_open_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            pos_q[i]   <= pos_d[i];
         end
         open_cw_q  <= open_cw_d;
         close_cw_q <= close_cw_d;
         is_open_q  <= is_open_d;
         busy_q     <= busy_d;
      end
   end

   assign OPEN_CW  = open_cw_q;
   assign CLOSE_CW = close_cw_q;
   assign IS_OPEN  = is_open_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_pbwc_multi.sv
// tb/tb_pbwc_multi.sv - directed vector bench for pbwc_multi (CH=4, DEB_CYCLES=4, TRAVEL_CYCLES=16)
module tb_pbwc_multi;

   logic       CLK;
   logic       RST;
   logic [3:0] PRESS;
   logic       ALL_CLOSE;
   logic [3:0] OPEN_CW;
   logic [3:0] CLOSE_CW;
   logic [3:0] IS_OPEN;
   logic       BUSY;

   int total = 0;
   int bad   = 0;

   pbwc_multi #(
      .CH(4),
      .DEB_CYCLES(4),
      .TRAVEL_CYCLES(16)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .PRESS    (PRESS),
      .ALL_CLOSE(ALL_CLOSE),
      .OPEN_CW  (OPEN_CW),
      .CLOSE_CW (CLOSE_CW),
      .IS_OPEN  (IS_OPEN),
      .BUSY     (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic [3:0] press;
      logic       all_close;
      int         n;
      logic [3:0] e_open;
      logic [3:0] e_close;
      logic [3:0] e_isopen;
      logic       e_busy;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic step(input string name, input logic [3:0] e_open, input logic [3:0] e_close,
                       input logic [3:0] e_isopen, input logic e_busy);
      logic [12:0] act, exp;
      act = {OPEN_CW, CLOSE_CW, IS_OPEN, BUSY};
      exp = {e_open, e_close, e_isopen, e_busy};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got open=%b close=%b is_open=%b busy=%b, want open=%b close=%b is_open=%b busy=%b",
                  name, OPEN_CW, CLOSE_CW, IS_OPEN, BUSY, e_open, e_close, e_isopen, e_busy);
      end
      total++;
      if ((OPEN_CW & CLOSE_CW) !== 4'b0000) begin
         bad++;
         $display("FAIL %s_excl: open&close=%b, want 0000", name, OPEN_CW & CLOSE_CW);
      end
   endtask

   initial begin
      logic [3:0] eo, ec, ei;

      RST       = 1'b0;
      PRESS     = 4'hF;
      ALL_CLOSE = 1'b0;

      // rst, press, all_close, cycles, open, close, is_open, busy
      tbl[0]  = '{1'b0, 4'hF, 1'b0,  2, 4'h0, 4'h0, 4'h0, 1'b0};  // held in reset, buttons down
      tbl[1]  = '{1'b1, 4'hF, 1'b0,  6, 4'h0, 4'h0, 4'h0, 1'b0};  // no event before the debounced rise
      tbl[2]  = '{1'b1, 4'hF, 1'b0,  1, 4'hF, 4'h0, 4'h0, 1'b1};  // all open on edge 7
      tbl[3]  = '{1'b0, 4'h0, 1'b0,  2, 4'h0, 4'h0, 4'h0, 1'b0};  // reset mid-travel
      tbl[4]  = '{1'b1, 4'h0, 1'b0,  2, 4'h0, 4'h0, 4'h0, 1'b0};  // idle after release
      tbl[5]  = '{1'b1, 4'h1, 1'b0,  6, 4'h0, 4'h0, 4'h0, 1'b0};  // ch0 press, edges 1..6
      tbl[6]  = '{1'b1, 4'h1, 1'b0, 16, 4'h1, 4'h0, 4'h0, 1'b1};  // ch0 opening, edges 7..22
      tbl[7]  = '{1'b1, 4'h1, 1'b0,  3, 4'h0, 4'h0, 4'h1, 1'b0};  // ch0 rests open, held button
      tbl[8]  = '{1'b1, 4'h0, 1'b0, 10, 4'h0, 4'h0, 4'h1, 1'b0};  // release gives no event
      tbl[9]  = '{1'b1, 4'h2, 1'b0,  3, 4'h0, 4'h0, 4'h1, 1'b0};  // ch1 3-cycle glitch
      tbl[10] = '{1'b1, 4'h0, 1'b0, 10, 4'h0, 4'h0, 4'h1, 1'b0};  // glitch ignored
      tbl[11] = '{1'b1, 4'h2, 1'b0,  4, 4'h0, 4'h0, 4'h1, 1'b0};  // ch1 4-cycle pulse
      tbl[12] = '{1'b1, 4'h0, 1'b0,  2, 4'h0, 4'h0, 4'h1, 1'b0};  // edges 5..6
      tbl[13] = '{1'b1, 4'h0, 1'b0, 16, 4'h2, 4'h0, 4'h1, 1'b1};  // ch1 opening
      tbl[14] = '{1'b1, 4'h0, 1'b0,  6, 4'h0, 4'h0, 4'h3, 1'b0};  // ch0, ch1 open

      for (int r = 0; r < NV; r++) begin
         RST       = tbl[r].rst;
         PRESS     = tbl[r].press;
         ALL_CLOSE = tbl[r].all_close;
         for (int k = 0; k < tbl[r].n; k++) begin
            tick();
            step($sformatf("vec%0d_c%0d", r, k), tbl[r].e_open, tbl[r].e_close,
                 tbl[r].e_isopen, tbl[r].e_busy);
         end
      end

      // ch2 reversed during OPENING at POS=7, the earliest a second debounced press can land.
      for (int e = 1; e <= 30; e++) begin
         PRESS = {1'b0, ((e >= 1 && e <= 4) || (e >= 9 && e <= 12)), 2'b00};
         tick();
         eo = (e >= 7 && e <= 14) ? 4'b0100 : 4'b0000;
         ec = (e >= 15 && e <= 21) ? 4'b0100 : 4'b0000;
         step($sformatf("rev_e%0d", e), eo, ec, 4'b0011, |(eo | ec));
      end

      // ALL_CLOSE with ch0/ch1 open, ch2 opening at POS=8, and a ch3 press that must be ignored.
      for (int e = 1; e <= 40; e++) begin
         PRESS     = {(e >= 17 && e <= 22), (e >= 1 && e <= 4), 2'b00};
         ALL_CLOSE = (e >= 16 && e <= 35);
         tick();
         eo = (e >= 7 && e <= 15) ? 4'b0100 : 4'b0000;
         ec = 4'b0000;
         if (e >= 16 && e <= 31) ec = ec | 4'b0011;
         if (e >= 16 && e <= 23) ec = ec | 4'b0100;
         ei = (e <= 15) ? 4'b0011 : 4'b0000;
         step($sformatf("allc_e%0d", e), eo, ec, ei, |(eo | ec));
      end
      ALL_CLOSE = 1'b0;

      // ch0 full open, then close, reset lands at POS=10 of the close.
      for (int e = 1; e <= 37; e++) begin
         PRESS = {3'b000, ((e >= 1 && e <= 4) || (e >= 25 && e <= 28))};
         tick();
         eo = (e >= 7 && e <= 22) ? 4'b0001 : 4'b0000;
         ei = (e >= 23 && e <= 30) ? 4'b0001 : 4'b0000;
         ec = (e >= 31) ? 4'b0001 : 4'b0000;
         step($sformatf("pre_rst_e%0d", e), eo, ec, ei, |(eo | ec));
      end
      #3;
      RST = 1'b0;
      #1;
      step("async_rst", 4'h0, 4'h0, 4'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         tick();
         step($sformatf("in_rst_c%0d", k), 4'h0, 4'h0, 4'h0, 1'b0);
      end
      RST = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         step($sformatf("post_rst_idle_e%0d", e), 4'h0, 4'h0, 4'h0, 1'b0);
      end
      for (int e = 1; e <= 25; e++) begin
         PRESS = {3'b000, (e >= 1 && e <= 4)};
         tick();
         eo = (e >= 7 && e <= 22) ? 4'b0001 : 4'b0000;
         ei = (e >= 23) ? 4'b0001 : 4'b0000;
         step($sformatf("post_rst_open_e%0d", e), eo, 4'h0, ei, |eo);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
